// File: rtl/otter_pkg.sv
// Shared definitions for the Otter multicycle control unit:
// RV32I opcode constants and the control FSM state type.
package otter_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_INTR,
        ST_FAULT
    } cu_state_t;

endpackage

// File: rtl/cu_timeout_ctr.sv
// Wait-cycle counter for memory handshakes.
// Ports: clk, rst_n (sync, active-low), clr (zero the count),
//        en (count one wait cycle), expire (count sits at MEM_TIMEOUT-1).
module cu_timeout_ctr #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned W =
        (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST =
        W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturates at LAST so a stalled FSM can never wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero timeout disables expiry entirely.
    assign expire = (MEM_TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/otter_cu_fsm_mc.sv
// Multicycle control FSM for the Otter MCU with ack-based memory,
// CSR/MRET decode, interrupt entry and a sticky memory-timeout fault.
// Inputs: clk, rst_n (sync, active-low), ir_opcode, ir_func,
//         imem_ack, dmem_ack, intr, csr_mie.
// Outputs: pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, reset,
//          csr_we, int_taken, mret_exec, illegal_op, bus_fault.
module otter_cu_fsm_mc
    import otter_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          HAS_INTR    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] ir_opcode,
    input  logic [2:0] ir_func,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic       intr,
    input  logic       csr_mie,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       mem_we2,
    output logic       reset,
    output logic       csr_we,
    output logic       int_taken,
    output logic       mret_exec,
    output logic       illegal_op,
    output logic       bus_fault
);

    cu_state_t state_q;
    cu_state_t state_d;
    cu_state_t ret_st;

    logic wait_en;
    logic cnt_clr;
    logic expire;
    logic is_load;

    cu_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (wait_en),
        .expire(expire)
    );

    // Every state change restarts the wait count for the new state.
    assign cnt_clr = (state_d != state_q);

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_rden1  = 1'b0;
        mem_rden2  = 1'b0;
        mem_we2    = 1'b0;
        reset      = 1'b0;
        csr_we     = 1'b0;
        int_taken  = 1'b0;
        mret_exec  = 1'b0;
        illegal_op = 1'b0;
        bus_fault  = 1'b0;
        wait_en    = 1'b0;
        is_load    = (ir_opcode == OP_LOAD);
        // Where an instruction goes after its last cycle.
        ret_st = (HAS_INTR && intr && csr_mie) ? ST_INTR : ST_FETCH;

        unique case (state_q)
            ST_INIT: begin
                reset   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                if (imem_ack) begin
                    state_d = ST_EXEC;
                end else begin
                    wait_en = 1'b1;
                    if (expire) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_EXEC: begin
                unique case (ir_opcode)
                    OP_LOAD: begin
                        mem_rden2 = 1'b1;
                        state_d   = ST_MEM;
                    end
                    OP_STORE: begin
                        mem_we2 = 1'b1;
                        state_d = ST_MEM;
                    end
                    OP_LUI, OP_AUIPC, OP_JAL,
                    OP_JALR, OP_IMM, OP_OP: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        state_d   = ret_st;
                    end
                    OP_BRANCH: begin
                        pc_write = 1'b1;
                        state_d  = ret_st;
                    end
                    OP_SYSTEM: begin
                        pc_write = 1'b1;
                        state_d  = ret_st;
                        if (ir_func != 3'b000) begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                        end else begin
                            mret_exec = 1'b1;
                        end
                    end
                    default: begin
                        illegal_op = 1'b1;
                        pc_write   = 1'b1;
                        state_d    = ret_st;
                    end
                endcase
            end
            ST_MEM: begin
                // IR is stable here, so it still tells load from store.
                mem_rden2 = is_load;
                mem_we2   = !is_load;
                if (dmem_ack) begin
                    if (is_load) begin
                        state_d = ST_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = ret_st;
                    end
                end else begin
                    wait_en = 1'b1;
                    if (expire) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_WB: begin
                pc_write  = 1'b1;
                reg_write = 1'b1;
                state_d   = ret_st;
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_FAULT: begin
                bus_fault = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_otter_cu_fsm_mc.sv
// Directed bench for otter_cu_fsm_mc: a phase-level model checked
// every cycle, plus literal output-pulse counts per instruction.
module tb_otter_cu_fsm_mc;

    localparam int T = 4;

    localparam int P_INIT  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC  = 2;
    localparam int P_MEM   = 3;
    localparam int P_WB    = 4;
    localparam int P_INTR  = 5;
    localparam int P_FAULT = 6;

    // Bit positions in the packed output vector.
    localparam int B_PC  = 10;
    localparam int B_REG = 9;
    localparam int B_R1  = 8;
    localparam int B_R2  = 7;
    localparam int B_WE2 = 6;
    localparam int B_RST = 5;
    localparam int B_CSR = 4;
    localparam int B_INT = 3;
    localparam int B_MRT = 2;
    localparam int B_ILL = 1;
    localparam int B_BF  = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opc;
    logic [2:0] fn;
    logic       iack;
    logic       dack;
    logic       irq;
    logic       mie;

    logic pc_write, reg_write, mem_rden1, mem_rden2, mem_we2;
    logic reset, csr_we, int_taken, mret_exec, illegal_op, bus_fault;

    logic [10:0] act;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int c [11];
    int s [11];

    int  mph = P_INIT;
    int  mw  = 0;
    bit  mvalid = 1'b0;

    always #5 clk = ~clk;

    otter_cu_fsm_mc #(
        .MEM_TIMEOUT(T),
        .HAS_INTR   (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir_opcode (opc),
        .ir_func   (fn),
        .imem_ack  (iack),
        .dmem_ack  (dack),
        .intr      (irq),
        .csr_mie   (mie),
        .pc_write  (pc_write),
        .reg_write (reg_write),
        .mem_rden1 (mem_rden1),
        .mem_rden2 (mem_rden2),
        .mem_we2   (mem_we2),
        .reset     (reset),
        .csr_we    (csr_we),
        .int_taken (int_taken),
        .mret_exec (mret_exec),
        .illegal_op(illegal_op),
        .bus_fault (bus_fault)
    );

    assign act = {pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
                  reset, csr_we, int_taken, mret_exec, illegal_op,
                  bus_fault};

    // Phase model: what each phase must drive and where it goes next.
    function automatic void model(
        input  int          ph,
        input  int          w,
        input  logic [6:0]  op,
        input  logic [2:0]  f,
        input  logic        ia,
        input  logic        da,
        input  logic        rq,
        input  logic        me,
        output logic [10:0] o,
        output int          nph,
        output int          nw
    );
        int fin;
        bit alu;
        o   = '0;
        nph = ph;
        fin = (rq && me) ? P_INTR : P_FETCH;
        alu = (op == 7'b0110111) || (op == 7'b0010111) ||
              (op == 7'b1101111) || (op == 7'b1100111) ||
              (op == 7'b0010011) || (op == 7'b0110011);
        if (ph == P_INIT) begin
            o[B_RST] = 1'b1;
            nph = P_FETCH;
        end else if (ph == P_FETCH) begin
            o[B_R1] = 1'b1;
            if (ia) nph = P_EXEC;
            else if (w == T - 1) nph = P_FAULT;
        end else if (ph == P_EXEC) begin
            if (op == 7'b0000011) begin
                o[B_R2] = 1'b1;
                nph = P_MEM;
            end else if (op == 7'b0100011) begin
                o[B_WE2] = 1'b1;
                nph = P_MEM;
            end else begin
                o[B_PC] = 1'b1;
                nph = fin;
                if (alu) begin
                    o[B_REG] = 1'b1;
                end else if (op == 7'b1100011) begin
                    o[B_PC] = 1'b1;
                end else if (op == 7'b1110011) begin
                    o[B_CSR] = (f != 0);
                    o[B_REG] = (f != 0);
                    o[B_MRT] = (f == 0);
                end else begin
                    o[B_ILL] = 1'b1;
                end
            end
        end else if (ph == P_MEM) begin
            o[B_R2]  = (op == 7'b0000011);
            o[B_WE2] = (op != 7'b0000011);
            if (da) begin
                if (op == 7'b0000011) begin
                    nph = P_WB;
                end else begin
                    o[B_PC] = 1'b1;
                    nph = fin;
                end
            end else if (w == T - 1) begin
                nph = P_FAULT;
            end
        end else if (ph == P_WB) begin
            o[B_PC]  = 1'b1;
            o[B_REG] = 1'b1;
            nph = fin;
        end else if (ph == P_INTR) begin
            o[B_INT] = 1'b1;
            o[B_PC]  = 1'b1;
            nph = P_FETCH;
        end else begin
            o[B_BF] = 1'b1;
        end
        nw = (nph == ph) ? w + 1 : 0;
    endfunction

    always @(posedge clk) begin
        logic [10:0] o;
        int nph;
        int nw;
        if (!rst_n) begin
            mph    = P_INIT;
            mw     = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            model(mph, mw, opc, fn, iack, dack, irq, mie, o, nph, nw);
            mph = nph;
            mw  = nw;
        end
    end

    always @(negedge clk) begin
        logic [10:0] o;
        int nph;
        int nw;
        if (mvalid) begin
            cyc_n++;
            model(mph, mw, opc, fn, iack, dack, irq, mie, o, nph, nw);
            n_cmp++;
            if (act !== o) begin
                n_bad++;
                $display("FAIL outputs cycle %0d phase %0d: got %b expected %b",
                         cyc_n, mph, act, o);
            end
            for (int k = 0; k < 11; k++) begin
                if (act[k] === 1'b1) c[k]++;
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        for (int k = 0; k < 11; k++) s[k] = c[k];
    endtask

    task automatic chk(input string nm, input int k, input int exp);
        int got;
        got = c[k] - s[k];
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    initial begin
        logic [6:0] alu_ops [5];
        alu_ops[0] = 7'b0110111;
        alu_ops[1] = 7'b0010111;
        alu_ops[2] = 7'b1101111;
        alu_ops[3] = 7'b1100111;
        alu_ops[4] = 7'b0110011;
        for (int k = 0; k < 11; k++) begin
            c[k] = 0;
            s[k] = 0;
        end
        rst_n = 1'b0;
        opc   = 7'b0010011;
        fn    = 3'd0;
        iack  = 1'b0;
        dack  = 1'b0;
        irq   = 1'b0;
        mie   = 1'b0;

        step(2);
        rst_n = 1'b1;
        snap();
        step(1);
        chk("reset_pulse", B_RST, 1);

        snap();
        step(3);
        chk("fetch_hold_rden1", B_R1, 3);
        chk("fetch_hold_pc", B_PC, 0);

        // 4th FETCH cycle sits at the timeout limit; ack must win.
        iack = 1'b1;
        snap();
        step(4);
        chk("addi_pc", B_PC, 2);
        chk("addi_reg", B_REG, 2);
        chk("addi_no_fault", B_BF, 0);

        opc = 7'b0000011;
        fn  = 3'd2;
        snap();
        step(4);
        dack = 1'b1;
        step(1);
        dack = 1'b0;
        step(1);
        chk("lw_rden2", B_R2, 4);
        chk("lw_pc", B_PC, 1);
        chk("lw_reg", B_REG, 1);

        opc = 7'b0100011;
        snap();
        step(2);
        dack = 1'b1;
        step(1);
        dack = 1'b0;
        chk("sw_we2", B_WE2, 2);
        chk("sw_pc", B_PC, 1);
        chk("sw_reg", B_REG, 0);

        opc = 7'b0110011;
        fn  = 3'd0;
        irq = 1'b1;
        mie = 1'b1;
        snap();
        step(3);
        chk("add_intr_taken", B_INT, 1);
        chk("add_intr_pc", B_PC, 2);

        mie = 1'b0;
        snap();
        step(2);
        chk("add_mie0_no_int", B_INT, 0);
        irq = 1'b0;

        for (int i = 0; i < 5; i++) begin
            opc = alu_ops[i];
            step(2);
        end

        opc = 7'b1100011;
        snap();
        step(2);
        chk("branch_reg", B_REG, 0);

        opc = 7'b1110011;
        fn  = 3'd1;
        snap();
        step(2);
        chk("csrrw_csr_we", B_CSR, 1);
        fn = 3'd0;
        snap();
        step(2);
        chk("mret_pulse", B_MRT, 1);
        opc = 7'b0001111;
        snap();
        step(2);
        chk("illegal_pulse", B_ILL, 1);

        opc = 7'b0100011;
        irq = 1'b1;
        mie = 1'b1;
        snap();
        step(2);
        dack = 1'b1;
        step(1);
        dack = 1'b0;
        step(1);
        chk("sw_intr_taken", B_INT, 1);

        opc = 7'b0110011;
        snap();
        step(1);
        irq = 1'b0;
        step(1);
        chk("intr_drop_no_int", B_INT, 0);

        iack = 1'b0;
        step(4);
        iack = 1'b1;
        snap();
        step(3);
        chk("fault_sticky", B_BF, 3);
        chk("fault_no_rden1", B_R1, 0);

        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        snap();
        step(1);
        chk("rst_clears_fault", B_BF, 0);

        opc = 7'b0000011;
        step(6);
        snap();
        step(2);
        chk("mem_timeout_fault", B_BF, 2);

        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
